// File: rtl/stage_execute_muldiv_pkg.sv
// Shared opcode and state definitions for the execute-stage multiply/divide unit.
// The decode stage imports the same codes to drive md_op and to derive md_in_decode.
package stage_execute_muldiv_pkg;

  localparam int MD_OP_LEN = 4;

  typedef enum logic [MD_OP_LEN-1:0] {
    MD_OP_NONE  = 4'd0,
    MD_OP_MULT  = 4'd1,
    MD_OP_MULTU = 4'd2,
    MD_OP_DIV   = 4'd3,
    MD_OP_DIVU  = 4'd4,
    MD_OP_MTHI  = 4'd5,
    MD_OP_MTLO  = 4'd6,
    MD_OP_MFHI  = 4'd7,
    MD_OP_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Ops that occupy the unit for several cycles and therefore stall decode.
  function automatic logic md_is_long(logic [MD_OP_LEN-1:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/stage_execute_muldiv.sv
// Execute-stage mult/div unit owning HI/LO; multi-cycle latency is a busy countdown,
// the arithmetic itself is combinational on the operands latched at the start edge.
module stage_execute_muldiv
  import stage_execute_muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [MD_OP_LEN-1:0] md_op,
  input  logic [31:0]          src0,
  input  logic [31:0]          src1,
  input  logic                 md_in_decode,
  output logic                 busy,
  output logic                 stall,
  output logic [31:0]          read_data,
  output logic [31:0]          hi,
  output logic [31:0]          lo
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  md_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MD_OP_LEN-1:0]   op_q, op_d;
  logic [31:0]            a_q, a_d, b_q, b_d;
  logic [31:0]            hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic        div_signed, div_op, res_we;
  logic [31:0] num, den_raw, den, q_mag, r_mag, quo, rem;
  logic [31:0] res_hi, res_lo;

  // Signed product: sign-extend to 64 bits, the low 64 bits of the product are exact.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign div_op     = (op_q == MD_OP_DIV) || (op_q == MD_OP_DIVU);
  assign div_signed = (op_q == MD_OP_DIV);
  assign num        = (div_signed && a_q[31]) ? -a_q : a_q;
  assign den_raw    = (div_signed && b_q[31]) ? -b_q : b_q;
  assign den        = (den_raw == 32'd0) ? 32'd1 : den_raw;
  assign q_mag      = num / den;
  assign r_mag      = num % den;
  assign quo        = (div_signed && (a_q[31] ^ b_q[31])) ? -q_mag : q_mag;
  assign rem        = (div_signed && a_q[31]) ? -r_mag : r_mag;
  assign res_we     = !(div_op && (b_q == 32'd0));

  always_comb begin
    res_hi = rem;
    res_lo = quo;
    if (op_q == MD_OP_MULT) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else if (op_q == MD_OP_MULTU) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (md_is_long(md_op)) begin
            op_d    = md_op;
            a_d     = src0;
            b_d     = src1;
            cnt_d   = ((md_op == MD_OP_MULT) || (md_op == MD_OP_MULTU)) ? MUL_LD : DIV_LD;
            state_d = ST_BUSY;
          end else if (md_op == MD_OP_MTHI) begin
            hi_d = src0;
          end else if (md_op == MD_OP_MTLO) begin
            lo_d = src0;
          end
        end
      end
      ST_BUSY: begin
        // start is ignored here; decode is stalled so it should never arrive.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          if (res_we) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == ST_BUSY);
  assign stall = md_in_decode && (busy || (start && md_is_long(md_op)));
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    read_data = 32'd0;
    if (md_op == MD_OP_MFHI)      read_data = hi_q;
    else if (md_op == MD_OP_MFLO) read_data = lo_q;
  end

endmodule

// File: tb/tb_stage_execute_muldiv.sv
// Directed bench for stage_execute_muldiv: spec-level model checked every cycle,
// plus hand-computed literal results for each directed vector.
module tb_stage_execute_muldiv;
  import stage_execute_muldiv_pkg::*;

  localparam int MUL_C = 5;
  localparam int DIV_C = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] src0 = 32'd0, src1 = 32'd0;
  logic        md_in_decode = 1'b0;
  logic        busy, stall;
  logic [31:0] read_data, hi, lo;

  int total = 0;
  int bad = 0;

  stage_execute_muldiv #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
    .src0(src0), .src1(src1), .md_in_decode(md_in_decode),
    .busy(busy), .stall(stall), .read_data(read_data), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Architectural result {hi,lo} from plain integer arithmetic.
  function automatic logic [63:0] model_res(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint          ps;
    longint unsigned pu;
    int              sa, sb, q, r;
    model_res = 64'd0;
    case (op)
      MD_OP_MULT: begin
        ps = longint'(int'(a)) * longint'(int'(b));
        model_res = ps;
      end
      MD_OP_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        model_res = pu;
      end
      MD_OP_DIV: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model_res = {32'd0, 32'h8000_0000};
        else if (b != 0) begin
          sa = a; sb = b; q = sa / sb; r = sa % sb;
          model_res = {r, q};
        end
      end
      MD_OP_DIVU: if (b != 0) model_res = {a % b, a / b};
      default: ;
    endcase
  endfunction

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_cnt;
  logic        m_wr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi <= 0; m_lo <= 0; m_cnt <= 0; m_wr <= 0; m_res <= 0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && m_wr) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
    end else if (start) begin
      case (md_op)
        MD_OP_MULT, MD_OP_MULTU: begin
          m_cnt <= MUL_C; m_wr <= 1'b1; m_res <= model_res(md_op, src0, src1);
        end
        MD_OP_DIV, MD_OP_DIVU: begin
          m_cnt <= DIV_C; m_wr <= (src1 != 0); m_res <= model_res(md_op, src0, src1);
        end
        MD_OP_MTHI: m_hi <= src0;
        MD_OP_MTLO: m_lo <= src0;
        default: ;
      endcase
    end
  end

  always @(posedge clk)
    assert (!(reset_n && start && m_cnt > 0)) else $error("protocol violation: start while busy");

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every sampled cycle goes through here: compare all outputs against the model.
  task automatic step();
    logic        e_busy, e_long;
    logic [31:0] e_rd;
    @(negedge clk);
    e_busy = (m_cnt > 0);
    e_long = md_op inside {MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU};
    e_rd   = (md_op == MD_OP_MFHI) ? m_hi : (md_op == MD_OP_MFLO) ? m_lo : 32'd0;
    chk("m_busy", {31'd0, busy}, {31'd0, e_busy});
    chk("m_stall", {31'd0, stall}, {31'd0, md_in_decode && (e_busy || (start && e_long))});
    chk("m_read_data", read_data, e_rd);
    chk("m_hi", hi, m_hi);
    chk("m_lo", lo, m_lo);
  endtask

  task automatic run_op(string nm, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                        logic mid, int exp_busy);
    int n;
    @(posedge clk); #1;
    start = 1'b1; md_op = op; src0 = a; src1 = b; md_in_decode = mid;
    step();
    chk({nm, "_stall_start"}, {31'd0, stall},
        {31'd0, mid && (op inside {MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU})});
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_OP_NONE; src0 = ~a; src1 = b + 32'd17;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!busy) break;
      n++;
      if (i == 2) begin src0 = 32'h1357_9BDF; src1 = 32'h0000_0003; end
    end
    chk({nm, "_busy_len"}, n, exp_busy);
    chk({nm, "_stall_after"}, {31'd0, stall}, 32'd0);
  endtask

  task automatic rd(string nm, logic [3:0] op, logic [31:0] exp);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; md_in_decode = 1'b0;
    step();
    chk(nm, read_data, exp);
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_OP_NONE;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    run_op("mult", MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, MUL_C);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    run_op("multu", MD_OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, MUL_C);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    run_op("div", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, DIV_C);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    run_op("divu0", MD_OP_DIVU, 32'd7, 32'd0, 1'b1, DIV_C);
    chk("divu0_hi", hi, 32'hFFFF_FFFF);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);

    run_op("divovf", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DIV_C);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    run_op("divu", MD_OP_DIVU, 32'd100, 32'd7, 1'b0, DIV_C);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    run_op("mthi", MD_OP_MTHI, 32'h1234_5678, 32'd0, 1'b1, 0);
    chk("mthi_hi", hi, 32'h1234_5678);
    rd("mfhi", MD_OP_MFHI, 32'h1234_5678);

    run_op("mtlo", MD_OP_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0, 0);
    chk("mtlo_lo", lo, 32'hCAFE_F00D);
    rd("mflo", MD_OP_MFLO, 32'hCAFE_F00D);

    rd("undef_rd", 4'hF, 32'd0);
    step();
    chk("undef_hi", hi, 32'h1234_5678);
    chk("undef_lo", lo, 32'hCAFE_F00D);

    // Abort a divide with reset during its fourth busy cycle.
    @(posedge clk); #1;
    start = 1'b1; md_op = MD_OP_DIV; src0 = 32'd100; src1 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; md_op = MD_OP_NONE;
    repeat (3) @(posedge clk);
    #1 chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    step();
    @(posedge clk); #1 reset_n = 1'b1;
    rd("abort_mflo", MD_OP_MFLO, 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
